// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path.
//   IMEM_DEPTH      : instruction memory size in bytes
//   BYTES_PER_INSTR : bytes per instruction (only 3 is supported)
//   fetch_state_e   : fetch controller state encoding
//   fetch_oob       : range check of a fetch start address
package cpu_pkg;
  localparam int IMEM_DEPTH      = 64;
  localparam int BYTES_PER_INSTR = 3;
  localparam int ADDR_W          = 24;
  localparam int INSTR_W         = 8 * BYTES_PER_INSTR;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // True when the last byte of an instruction starting at pc lies past the
  // end of memory. Done in 25 bits so a PC near 2^24 cannot wrap back into range.
  function automatic logic fetch_oob(input logic [ADDR_W-1:0] pc, input int depth);
    return ({1'b0, pc} + 25'(BYTES_PER_INSTR - 1)) > 25'(depth - 1);
  endfunction
endpackage

// File: rtl/fetch_assembler.sv
// Collects the three bytes of an instruction into a big-endian word.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   clr_i   : discard everything collected so far (wins over vld_i)
//   vld_i   : data_i carries byte idx_i of the current instruction
//   idx_i   : byte index 0..2 (0 is the most significant byte)
//   data_i  : byte from instruction memory
//   instr_o : assembled instruction
module fetch_assembler
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               vld_i,
  input  logic [1:0]         idx_i,
  input  logic [7:0]         data_i,
  output logic [INSTR_W-1:0] instr_o
);
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    instr_d = instr_q;
    if (clr_i) begin
      instr_d = '0;
    end else if (vld_i) begin
      case (idx_i)
        2'd0:    instr_d[23:16] = data_i;
        2'd1:    instr_d[15:8]  = data_i;
        2'd2:    instr_d[7:0]   = data_i;
        default: instr_d = instr_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) instr_q <= '0;
    else         instr_q <= instr_d;
  end

  assign instr_o = instr_q;
endmodule

// File: rtl/fetch_controller.sv
// Fetches 3-byte instructions from a byte-wide memory with one-cycle read
// latency and presents them on a valid/ready interface.
//   Clock, Reset      : clock, synchronous active-low reset
//   MemAddr, MemRdEn  : byte read request to instruction memory
//   MemData           : byte returned one cycle after MemRdEn
//   Instruction       : assembled big-endian instruction
//   InstrPC           : byte address of Instruction
//   InstrValid        : Instruction/InstrPC valid
//   InstrReady        : consumer accepts when InstrValid & InstrReady
//   Redirect          : restart fetch at RedirectAddr (highest priority)
//   RedirectAddr      : new PC
//   Fault             : fetch address out of range, sticky until Redirect
module fetch_controller #(
  parameter int IMEM_DEPTH      = cpu_pkg::IMEM_DEPTH,
  parameter int BYTES_PER_INSTR = cpu_pkg::BYTES_PER_INSTR
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [23:0] MemAddr,
  output logic        MemRdEn,
  input  logic [7:0]  MemData,
  output logic [23:0] Instruction,
  output logic [23:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [23:0] RedirectAddr,
  output logic        Fault
);
  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [23:0]  pc_q, pc_d;
  logic [23:0]  ipc_q, ipc_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         cap_vld_q;   // a read was issued last cycle; its byte is on MemData
  logic [1:0]   cap_idx_q;   // byte index of that read
  logic         oob;
  logic         issue;

  assign oob = fetch_oob(pc_q, IMEM_DEPTH);

  // The first read of an out-of-range instruction is suppressed. Gating with
  // Reset keeps the strobe low for as long as reset is held.
  assign issue      = Reset && (state_q == ST_ISSUE) && !((cnt_q == 2'd0) && oob);
  assign MemRdEn    = issue;
  assign MemAddr    = pc_q + {22'd0, cnt_q};
  assign InstrValid = (state_q == ST_VALID);
  assign Fault      = (state_q == ST_FAULT);
  assign InstrPC    = ipc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ipc_d   = ipc_q;
    if (Redirect) begin
      // Also covers redirect during a handshake: the transfer completes but
      // fetch continues from RedirectAddr.
      state_d = ST_ISSUE;
      pc_d    = RedirectAddr;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if ((cnt_q == 2'd0) && oob) begin
            state_d = ST_FAULT;
          end else if (cnt_q == 2'd2) begin
            cnt_d   = 2'd0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        ST_DRAIN: begin
          ipc_d   = pc_q;
          state_d = ST_VALID;
        end
        ST_VALID: begin
          if (InstrReady) begin
            pc_d    = pc_q + 24'(BYTES_PER_INSTR);
            state_d = ST_ISSUE;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_ISSUE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= ST_ISSUE;
      pc_q      <= '0;
      cnt_q     <= '0;
      ipc_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      ipc_q     <= ipc_d;
      // A read issued in the redirect cycle belongs to the abandoned fetch.
      cap_vld_q <= issue && !Redirect;
      cap_idx_q <= cnt_q;
    end
  end

  fetch_assembler u_asm (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .clr_i   (Redirect),
    .vld_i   (cap_vld_q),
    .idx_i   (cap_idx_q),
    .data_i  (MemData),
    .instr_o (Instruction)
  );
endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
  localparam int DEPTH = 64;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [23:0] MemAddr;
  logic        MemRdEn;
  logic [7:0]  MemData = 8'h00;
  logic [23:0] Instruction;
  logic [23:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic        Redirect = 1'b0;
  logic [23:0] RedirectAddr = 24'h0;
  logic        Fault;

  logic [7:0]  mem [DEPTH];
  int          n_chk = 0;
  int          n_pass = 0;
  int          oob_rd = 0;

  // Reference model: PC, cycles elapsed in the current fetch (0..4, 4 = holding
  // a valid instruction) and the sticky fault flag.
  logic [23:0] m_pc;
  int          m_t;
  bit          m_fault;

  fetch_controller #(.IMEM_DEPTH(DEPTH), .BYTES_PER_INSTR(3)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .MemAddr      (MemAddr),
    .MemRdEn      (MemRdEn),
    .MemData      (MemData),
    .Instruction  (Instruction),
    .InstrPC      (InstrPC),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .Redirect     (Redirect),
    .RedirectAddr (RedirectAddr),
    .Fault        (Fault)
  );

  always #5 Clock = ~Clock;

  // Instruction memory: data returned one cycle after the strobe.
  always @(posedge Clock) begin
    if (MemRdEn === 1'b1) begin
      if (MemAddr >= 24'(DEPTH)) oob_rd++;
      MemData <= mem[MemAddr[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit m_oob(input logic [23:0] pc);
    return (int'(pc) + 2) > (DEPTH - 1);
  endfunction

  function automatic logic [23:0] word_at(input logic [23:0] pc);
    return {mem[pc[5:0]], mem[pc[5:0] + 6'd1], mem[pc[5:0] + 6'd2]};
  endfunction

  // Advance the model across a clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (!Reset) begin
      m_pc = '0; m_t = 0; m_fault = 1'b0;
    end else if (Redirect) begin
      m_pc = RedirectAddr; m_t = 0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_t = 0;
    end else if (m_t == 0 && m_oob(m_pc)) begin
      m_fault = 1'b1;
    end else if (m_t >= 4) begin
      if (InstrReady) begin
        m_pc = m_pc + 24'd3;
        m_t  = 0;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic model_cmp();
    bit exp_rd;
    exp_rd = Reset && !m_fault && (m_t < 3) && !(m_t == 0 && m_oob(m_pc));
    chk("rden", MemRdEn, exp_rd);
    if (exp_rd) chk("addr", MemAddr, m_pc + 24'(m_t));
    chk("valid", InstrValid, !m_fault && m_t == 4);
    chk("fault", Fault, m_fault);
    if (!m_fault && m_t == 4) begin
      chk("instr", Instruction, word_at(m_pc));
      chk("ipc", InstrPC, m_pc);
    end
  endtask

  task automatic step(input bit rst, input bit rdy, input bit redir, input logic [23:0] ra);
    @(posedge Clock);
    #1;
    model_edge();
    Reset = rst; InstrReady = rdy; Redirect = redir; RedirectAddr = ra;
    @(negedge Clock);
    model_cmp();
  endtask

  task automatic to_valid();
    for (int i = 0; i < 8 && InstrValid !== 1'b1; i++) step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("to_valid", InstrValid, 1'b1);
  endtask

  function automatic logic [23:0] pick_addr();
    case ($urandom % 4)
      0:       return 24'($urandom % 62);
      1:       return 24'(55 + $urandom % 9);
      2:       return 24'hFFFFF0 + 24'($urandom % 16);
      default: return 24'(3 * ($urandom % 20));
    endcase
  endfunction

  initial begin
    int first, second;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    mem[3] = 8'hAB; mem[4] = 8'hCD; mem[5] = 8'hEF;
    m_pc = '0; m_t = 0; m_fault = 1'b0;
    repeat (2) @(posedge Clock);

    // Two back-to-back instructions, 5 cycles apart.
    first = -1; second = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i != 9, 1'b0, 24'h0);
      if (i == 0) chk("first_rd_addr0", {MemRdEn, MemAddr}, {1'b1, 24'h0});
      if (InstrValid === 1'b1) begin
        if (first < 0) begin
          first = i;
          chk("i0", Instruction, 24'h123456);
          chk("pc0", InstrPC, 24'h0);
        end else if (second < 0) begin
          second = i;
          chk("i1", Instruction, 24'hABCDEF);
          chk("pc1", InstrPC, 24'h3);
        end
      end
    end
    chk("first_latency", first, 4);
    chk("gap", second - first, 5);

    // Back-pressure: hold for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 24'h0);
      chk("hold_instr", Instruction, 24'hABCDEF);
      chk("hold_ipc", InstrPC, 24'h3);
      chk("hold_vld", InstrValid, 1'b1);
      chk("hold_rd", MemRdEn, 1'b0);
    end

    // Redirect during the cnt=1 read of the fetch at PC 6.
    step(1'b1, 1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b1, 24'h9);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("redir_addr", {MemRdEn, MemAddr}, {1'b1, 24'h9});
    to_valid();
    chk("redir_ipc", InstrPC, 24'h9);

    // Redirect together with a handshake.
    step(1'b1, 1'b1, 1'b1, 24'h6);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("hs_redir_addr", {MemRdEn, MemAddr}, {1'b1, 24'h6});
    to_valid();

    // PC 60 still fits; the next one at 63 faults.
    step(1'b1, 1'b1, 1'b1, 24'd60);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("pc60_rd", {MemRdEn, MemAddr}, {1'b1, 24'd60});
    to_valid();
    chk("pc60_ipc", InstrPC, 24'd60);
    step(1'b1, 1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("pc63_nord", MemRdEn, 1'b0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("pc63_fault", Fault, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b1, 24'h0);
    chk("fault_sticky", Fault, 1'b1);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("fault_clr", Fault, 1'b0);
    chk("fault_clr_rd", {MemRdEn, MemAddr}, {1'b1, 24'h0});

    // Range check must not wrap at 2^24.
    step(1'b1, 1'b0, 1'b1, 24'hFFFFFE);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("wrap_nord", MemRdEn, 1'b0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("wrap_fault", Fault, 1'b1);
    step(1'b1, 1'b0, 1'b1, 24'd61);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("pc61_rd", {MemRdEn, MemAddr}, {1'b1, 24'd61});
    to_valid();
    chk("pc61_ipc", InstrPC, 24'd61);

    // One-cycle reset landing on the DRAIN cycle.
    step(1'b1, 1'b1, 1'b1, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b0, 1'b0, 1'b0, 24'h0);
    @(posedge Clock);
    #1;
    model_edge();
    chk("rst_instr", Instruction, 24'h0);
    chk("rst_ipc", InstrPC, 24'h0);
    chk("rst_vld", InstrValid, 1'b0);
    chk("rst_fault", Fault, 1'b0);
    chk("rst_rd", MemRdEn, 1'b0);
    chk("rst_addr", MemAddr, 24'h0);
    Reset = 1'b1; InstrReady = 1'b1; Redirect = 1'b0;
    @(negedge Clock);
    model_cmp();
    chk("rst_first_rd", {MemRdEn, MemAddr}, {1'b1, 24'h0});
    repeat (6) step(1'b1, 1'b1, 1'b0, 24'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 100) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0, pick_addr());

    chk("no_oob_reads", oob_rd, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
